// File: rtl/mdu_sequencer.sv
// Control FSM for the carry-save multiply/divide kernel: load, iterate, save remainder, sign fix, done.
// Optional divide-by-zero bypass enabled by defining MDU_DIV0_BYPASS_EN.
module mdu_sequencer #(
  parameter int parallelism = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_opCode,
  input  logic       dividend_sign,
  input  logic       rem_sign,
  input  logic       rem_zero,
  input  logic       divisor_zero,
  output logic [2:0] opCode,
  output logic       load_en,
  output logic       iter_en,
  output logic       saveReminder,
  output logic       corr_en,
  output logic       res_sel_hi,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       div0_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_SAVE,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(parallelism - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(parallelism);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       opcode_q;
  logic             load_en_q;
  logic             iter_en_q;
  logic             save_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             iter_last;
  logic             div0_req;
  logic             div0_q;

  assign iter_last = (cnt_q == (opcode_q[2] ? DIV_LAST : MUL_LAST));

`ifdef MDU_DIV0_BYPASS_EN
  logic div0_flag_q;

  assign div0_req = opcode_q[2] & divisor_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div0_q      <= 1'b0;
      div0_flag_q <= 1'b0;
    end else begin
      if (state_q == S_LOAD) begin
        div0_q <= div0_req;
      end
      if (state_q == S_FIX) begin
        div0_flag_q <= div0_q;
      end else if ((state_q == S_DONE) && out_ready) begin
        div0_flag_q <= 1'b0;
        div0_q      <= 1'b0;
      end
    end
  end

  assign div0_flag = div0_flag_q;
`else
  logic unused_divisor_zero;

  assign unused_divisor_zero = divisor_zero;
  assign div0_req            = 1'b0;
  assign div0_q              = 1'b0;
  assign div0_flag           = 1'b0;
`endif

  // Every operation passes through FIX so multiply and bypass paths get their
  // settle cycle; correction only fires for a real divide, sampling the final
  // remainder status in that cycle.
  assign corr_en = (state_q == S_FIX) && opcode_q[2] && !div0_q && !rem_zero &&
                   (rem_sign != (opcode_q[0] ? 1'b0 : dividend_sign));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opcode_q    <= '0;
      load_en_q   <= 1'b0;
      iter_en_q   <= 1'b0;
      save_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      load_en_q <= 1'b0;
      save_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            opcode_q   <= in_opCode;
            state_q    <= S_LOAD;
            load_en_q  <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        S_LOAD: begin
          cnt_q <= '0;
          if (div0_req) begin
            state_q <= S_FIX;
          end else begin
            state_q   <= S_ITER;
            iter_en_q <= 1'b1;
          end
        end
        S_ITER: begin
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (iter_last) begin
            iter_en_q <= 1'b0;
            save_q    <= opcode_q[2];
            state_q   <= opcode_q[2] ? S_SAVE : S_FIX;
          end
        end
        S_SAVE: begin
          state_q <= S_FIX;
        end
        S_FIX: begin
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          iter_en_q   <= 1'b0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign opCode       = opcode_q;
  assign res_sel_hi   = opcode_q[1];
  assign load_en      = load_en_q;
  assign iter_en      = iter_en_q;
  assign saveReminder = save_q;
  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer: latencies, strobe counts, correction decode,
// DONE back-pressure, asynchronous abort and the optional divide-by-zero bypass.
module tb_mdu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opCode;
  logic       dividend_sign;
  logic       rem_sign;
  logic       rem_zero;
  logic       divisor_zero;
  logic [2:0] opCode;
  logic       load_en;
  logic       iter_en;
  logic       saveReminder;
  logic       corr_en;
  logic       res_sel_hi;
  logic       out_valid;
  logic       out_ready;
  logic       div0_flag;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_sequencer #(
    .parallelism(32),
    .CNT_W      (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opCode    (in_opCode),
    .dividend_sign(dividend_sign),
    .rem_sign     (rem_sign),
    .rem_zero     (rem_zero),
    .divisor_zero (divisor_zero),
    .opCode       (opCode),
    .load_en      (load_en),
    .iter_en      (iter_en),
    .saveReminder (saveReminder),
    .corr_en      (corr_en),
    .res_sel_hi   (res_sel_hi),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .div0_flag    (div0_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in IDLE and returns just after the accepting edge.
  task automatic issue(input string tag, input logic [2:0] op);
    in_opCode = op;
    in_valid  = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Starts at the sample just after the accepting edge (edge 0) and runs to out_valid.
  task automatic track(input string tag, input int exp_lat, input int exp_iter,
                       input int exp_save, input int exp_corr, input logic exp_div0,
                       input logic exp_hi, input bit ack);
    int n     = 0;
    int nl    = 0;
    int ni    = 0;
    int ns    = 0;
    int nc    = 0;
    int multi = 0;
    while (!out_valid && n < 100) begin
      nl += int'(load_en);
      ni += int'(iter_en);
      ns += int'(saveReminder);
      nc += int'(corr_en);
      if (int'(load_en) + int'(iter_en) + int'(saveReminder) + int'(corr_en) > 1) multi++;
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_load_cycles"}, 32'(nl), 32'd1);
    check({tag, "_iter_cycles"}, 32'(ni), 32'(exp_iter));
    check({tag, "_save_cycles"}, 32'(ns), 32'(exp_save));
    check({tag, "_corr_cycles"}, 32'(nc), 32'(exp_corr));
    check({tag, "_strobe_overlap"}, 32'(multi), 32'd0);
    check({tag, "_res_sel_hi"}, 32'(res_sel_hi), 32'(exp_hi));
    check({tag, "_div0_flag"}, 32'(div0_flag), 32'(exp_div0));
    check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
    if (ack) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_ack_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_ack_div0"}, 32'(div0_flag), 32'd0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_opCode     = 3'b000;
    dividend_sign = 1'b0;
    rem_sign      = 1'b0;
    rem_zero      = 1'b0;
    divisor_zero  = 1'b0;
    out_ready     = 1'b0;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_strobes", 32'({load_en, iter_en, saveReminder, corr_en}), 32'd0);
    check("rst_opCode", 32'(opCode), 32'd0);
    check("rst_div0", 32'(div0_flag), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    issue("mul", 3'b000);
    track("mul", 34, 32, 0, 0, 1'b0, 1'b0, 1'b1);

    dividend_sign = 1'b1; rem_sign = 1'b0; rem_zero = 1'b0;
    issue("div_s_fix", 3'b110);
    check("div_s_fix_opCode", 32'(opCode), 32'd6);
    track("div_s_fix", 36, 33, 1, 1, 1'b0, 1'b1, 1'b1);

    dividend_sign = 1'b0; rem_sign = 1'b0; rem_zero = 1'b1;
    issue("div_u_zero", 3'b101);
    track("div_u_zero", 36, 33, 1, 0, 1'b0, 1'b0, 1'b1);

    rem_sign = 1'b1; rem_zero = 1'b0;
    issue("div_u_neg", 3'b101);
    track("div_u_neg", 36, 33, 1, 1, 1'b0, 1'b0, 1'b1);

    dividend_sign = 1'b1; rem_sign = 1'b1; rem_zero = 1'b0;
    issue("div_s_ok", 3'b110);
    track("div_s_ok", 36, 33, 1, 0, 1'b0, 1'b1, 1'b1);

    dividend_sign = 1'b0; rem_sign = 1'b1; rem_zero = 1'b0;
    issue("mulh", 3'b010);
    track("mulh", 34, 32, 0, 0, 1'b0, 1'b1, 1'b1);

    out_ready = 1'b1;
    tick();
    tick();
    check("idle_ack_valid", 32'(out_valid), 32'd0);
    check("idle_ack_ready", 32'(in_ready), 32'd1);
    check("idle_ack_load", 32'(load_en), 32'd0);
    out_ready = 1'b0;

    issue("hold", 3'b000);
    track("hold", 34, 32, 0, 0, 1'b0, 1'b0, 1'b0);
    in_valid  = 1'b1;
    in_opCode = 3'b001;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_load", 32'(load_en), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b_idle_valid", 32'(out_valid), 32'd0);
    check("b2b_idle_ready", 32'(in_ready), 32'd1);
    check("b2b_idle_load", 32'(load_en), 32'd0);
    tick();
    in_valid = 1'b0;
    check("b2b_load", 32'(load_en), 32'd1);
    check("b2b_opCode", 32'(opCode), 32'd1);
    track("b2b", 34, 32, 0, 0, 1'b0, 1'b0, 1'b1);

    issue("abort", 3'b000);
    repeat (11) tick();
    check("abort_pre_iter", 32'(iter_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_iter", 32'(iter_en), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_opCode", 32'(opCode), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_no_result", 32'(out_valid), 32'd0);
    issue("post_rst", 3'b000);
    track("post_rst", 34, 32, 0, 0, 1'b0, 1'b0, 1'b1);

    divisor_zero = 1'b1; rem_zero = 1'b1;
    issue("div0", 3'b100);
`ifdef MDU_DIV0_BYPASS_EN
    track("div0", 2, 0, 0, 0, 1'b1, 1'b0, 1'b1);
`else
    track("div0", 36, 33, 1, 0, 1'b0, 1'b0, 1'b1);
`endif
    divisor_zero = 1'b0; rem_zero = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
